// File: rtl/branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// branch_predict_ctrl
//
// Branch prediction and redirect controller for the pipelined RISC-V core.
// A table of 2-bit saturating counters supplies a taken/not-taken prediction
// to fetch. Conditional branches are resolved in EX from the ALU flags and
// funct3. A misprediction starts a one-cycle PC redirect and a two-cycle
// pipeline flush.
//
// Optional feature macro: BRANCH_PREDICT_STATS_EN
//   defined   -> branch_count / mispredict_count are saturating counters
//   undefined -> both outputs are tied to 0 and no counter flops exist
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   if_pc                 fetch PC; pred_taken is its combinational prediction
//   ex_valid, ex_branch   EX holds a valid conditional branch
//   ex_funct3             branch condition select
//   ex_pred_taken         prediction that travelled with the EX instruction
//   ex_pc, ex_target      EX PC and computed branch target
//   Carry_Flag, Zero_Flag, Overflow_Flag, Sign_Flag  ALU compare flags
//   redirect_valid        one-cycle pulse: load redirect_pc into the PC
//   redirect_pc           corrected fetch address (registered)
//   flush                 squash IF/ID and ID/EX for two cycles
//   branch_count, mispredict_count  statistics
// ---------------------------------------------------------------------------
module branch_predict_ctrl #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  input  logic            Carry_Flag,
  input  logic            Zero_Flag,
  input  logic            Overflow_Flag,
  input  logic            Sign_Flag,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH1 = 2'd1,
    FLUSH2 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic            flush_q, flush_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]      ctr_q [ENTRIES];
  logic [1:0]      ctr_d [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond_branch;
  logic             taken;
  logic             resolve;
  logic             mispredict;

  // Only the index bits of if_pc feed the table; the rest is intentionally unused.
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Read the registered counter, so a same-cycle update is not yet visible.
  assign pred_taken = ctr_q[if_idx][1];

  // Branch condition from ALU flags; funct3 010/011 is not a conditional branch.
  always_comb begin
    taken       = 1'b0;
    cond_branch = 1'b1;
    case (ex_funct3)
      3'b000:  taken = Zero_Flag;
      3'b001:  taken = ~Zero_Flag;
      3'b100:  taken = Overflow_Flag ^ Sign_Flag;
      3'b101:  taken = ~(Overflow_Flag ^ Sign_Flag);
      3'b110:  taken = ~Carry_Flag;
      3'b111:  taken = Carry_Flag;
      default: cond_branch = 1'b0;
    endcase
  end

  // Wrong-path instructions sitting in EX during a flush are ignored.
  assign resolve    = ex_valid & ex_branch & cond_branch & (state_q == IDLE);
  assign mispredict = resolve & (taken != ex_pred_taken);

  // Saturating counter update for the resolving branch.
  always_comb begin
    ctr_d = ctr_q;
    if (resolve) begin
      if (taken) begin
        if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'b01;
      end else begin
        if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'b01;
      end
    end
  end

  // Next state and the registered outputs that belong to it.
  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          state_d       = FLUSH1;
          redirect_pc_d = taken ? ex_target : ex_pc + PC_W'(4);
        end
      end
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    redirect_valid_d = (state_d == FLUSH1);
    flush_d          = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Statistics saturate rather than wrap.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (resolve && branch_count_q != 32'hFFFF_FFFF)
      branch_count_d = branch_count_q + 32'd1;
    if (mispredict && mispredict_count_q != 32'hFFFF_FFFF)
      mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_ctrl
//
// Directed bench for branch_predict_ctrl with hand-computed expectations.
// Note: with ENTRIES=16 the PCs 0x40, 0x100 and 0x200 all map to index 0,
// so the BEQ, BLTU and BGE scenarios share and chain one counter.
// ---------------------------------------------------------------------------
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_branch;
  logic [2:0]  ex_funct3;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        Carry_Flag, Zero_Flag, Overflow_Flag, Sign_Flag;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] branch_count, mispredict_count;

  int check_count = 0;
  int pass_count  = 0;

  branch_predict_ctrl #(.ENTRIES(16), .PC_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_funct3        (ex_funct3),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pc            (ex_pc),
    .ex_target        (ex_target),
    .Carry_Flag       (Carry_Flag),
    .Zero_Flag        (Zero_Flag),
    .Overflow_Flag    (Overflow_Flag),
    .Sign_Flag        (Sign_Flag),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] tgt, input logic pred,
                            input logic c, input logic z, input logic v,
                            input logic s);
    ex_valid      = 1'b1;
    ex_branch     = 1'b1;
    ex_funct3     = f3;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    Carry_Flag    = c;
    Zero_Flag     = z;
    Overflow_Flag = v;
    Sign_Flag     = s;
  endtask

  task automatic clear_ex();
    ex_valid  = 1'b0;
    ex_branch = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_pc = '0;
    clear_ex();
    set_branch(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_ex();
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      check_count++;
      if (pred_taken !== 1'b0)
        $display("[TB] FAIL reset_pred idx%0d: got %b expected 0", i, pred_taken);
      else pass_count++;
    end
    check_count++;
    if (redirect_valid !== 1'b0) $display("[TB] FAIL reset_redirect_valid: got %b expected 0", redirect_valid);
    else pass_count++;
    check_count++;
    if (flush !== 1'b0) $display("[TB] FAIL reset_flush: got %b expected 0", flush);
    else pass_count++;
    check_count++;
    if (redirect_pc !== 32'h0) $display("[TB] FAIL reset_redirect_pc: got %h expected 0", redirect_pc);
    else pass_count++;
    check_count++;
    if (branch_count !== 32'h0 || mispredict_count !== 32'h0)
      $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    else pass_count++;
  endtask

  task automatic test_beq_mispredict();
    set_branch(3'b000, 32'h100, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80)
      $display("[TB] FAIL beq_redirect: got %b/%h expected 1/00000080", redirect_valid, redirect_pc);
    else pass_count++;
    check_count++;
    if (flush !== 1'b1) $display("[TB] FAIL beq_flush_n1: got %b expected 1", flush);
    else pass_count++;
    step();
    check_count++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1)
      $display("[TB] FAIL beq_n2: got rv=%b fl=%b expected rv=0 fl=1", redirect_valid, flush);
    else pass_count++;
    step();
    check_count++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("[TB] FAIL beq_n3: got rv=%b fl=%b expected 0/0", redirect_valid, flush);
    else pass_count++;
    if_pc = 32'h100;
    #1;
    check_count++;
    if (pred_taken !== 1'b1) $display("[TB] FAIL beq_trained_pred: got %b expected 1", pred_taken);
    else pass_count++;
  endtask

  task automatic test_bltu_not_taken();
    if_pc = 32'h200;
    #1;
    check_count++;
    if (pred_taken !== 1'b1) $display("[TB] FAIL bltu_pre_pred: got %b expected 1", pred_taken);
    else pass_count++;
    set_branch(3'b110, 32'h200, 32'h900, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204)
      $display("[TB] FAIL bltu_redirect: got %b/%h expected 1/00000204", redirect_valid, redirect_pc);
    else pass_count++;
    check_count++;
    if (pred_taken !== 1'b0) $display("[TB] FAIL bltu_post_pred: got %b expected 0", pred_taken);
    else pass_count++;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int redirects;
    redirects = 0;
    set_branch(3'b101, 32'h40, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clear_ex();
    if (redirect_valid === 1'b1) redirects++;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      set_branch(3'b101, 32'h40, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      if (redirect_valid === 1'b1 || flush === 1'b1) redirects++;
    end
    clear_ex();
    check_count++;
    if (redirects !== 1) $display("[TB] FAIL sat_redirects: got %0d expected 1", redirects);
    else pass_count++;
    if_pc = 32'h40;
    #1;
    check_count++;
    if (pred_taken !== 1'b1) $display("[TB] FAIL sat_pred: got %b expected 1", pred_taken);
    else pass_count++;
    // Counter is at 3; one not-taken drops it to 2, still predicting taken.
    set_branch(3'b101, 32'h40, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (pred_taken !== 1'b1) $display("[TB] FAIL sat_after_nt_pred: got %b expected 1", pred_taken);
    else pass_count++;
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44)
      $display("[TB] FAIL sat_nt_redirect: got %b/%h expected 1/00000044", redirect_valid, redirect_pc);
    else pass_count++;
    step();
    step();
  endtask

  task automatic test_flush_shadow();
    set_branch(3'b000, 32'h08, 32'h300, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    // Wrong-path BNE that would mispredict if it were resolved.
    set_branch(3'b001, 32'h0C, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300)
      $display("[TB] FAIL shadow_first: got %b/%h expected 1/00000300", redirect_valid, redirect_pc);
    else pass_count++;
    step();
    check_count++;
    if (redirect_valid !== 1'b0 || flush !== 1'b1 || redirect_pc !== 32'h300)
      $display("[TB] FAIL shadow_f2: got rv=%b fl=%b pc=%h expected 0/1/00000300", redirect_valid, flush, redirect_pc);
    else pass_count++;
    step();
    check_count++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("[TB] FAIL shadow_idle: got rv=%b fl=%b expected 0/0", redirect_valid, flush);
    else pass_count++;
    clear_ex();
    if_pc = 32'h0C;
    #1;
    check_count++;
    if (pred_taken !== 1'b0) $display("[TB] FAIL shadow_ctr_unchanged: got %b expected 0", pred_taken);
    else pass_count++;
    step();
    check_count++;
    if (redirect_valid !== 1'b0) $display("[TB] FAIL shadow_no_late_redirect: got %b expected 0", redirect_valid);
    else pass_count++;
    // Abort a flush sequence with reset while in FLUSH1.
    set_branch(3'b001, 32'h0C, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (flush !== 1'b1) $display("[TB] FAIL abort_pre_flush: got %b expected 1", flush);
    else pass_count++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_count++;
    if (flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0)
      $display("[TB] FAIL abort_outputs: got fl=%b rv=%b pc=%h expected 0/0/0", flush, redirect_valid, redirect_pc);
    else pass_count++;
    step();
    check_count++;
    if (flush !== 1'b0) $display("[TB] FAIL abort_stays_idle: got %b expected 0", flush);
    else pass_count++;
  endtask

  task automatic test_stats();
    logic [31:0] exp_br, exp_mp;
    set_branch(3'b000, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_branch(3'b001, 32'h14, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500)
      $display("[TB] FAIL stats_bne_redirect: got %b/%h expected 1/00000500", redirect_valid, redirect_pc);
    else pass_count++;
    step();
    step();
    set_branch(3'b100, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_branch(3'b111, 32'h1C, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h600)
      $display("[TB] FAIL stats_bgeu_redirect: got %b/%h expected 1/00000600", redirect_valid, redirect_pc);
    else pass_count++;
    step();
    step();
    set_branch(3'b110, 32'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_branch(3'b010, 32'h24, 32'h800, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    clear_ex();
    check_count++;
    if (redirect_valid !== 1'b0 || flush !== 1'b0)
      $display("[TB] FAIL stats_f3_010_ignored: got rv=%b fl=%b expected 0/0", redirect_valid, flush);
    else pass_count++;
    if_pc = 32'h10;
    #1;
    check_count++;
    if (pred_taken !== 1'b0) $display("[TB] FAIL stats_beq_nt_pred: got %b expected 0", pred_taken);
    else pass_count++;
    if_pc = 32'h1C;
    #1;
    check_count++;
    if (pred_taken !== 1'b1) $display("[TB] FAIL stats_bgeu_pred: got %b expected 1", pred_taken);
    else pass_count++;
`ifdef BRANCH_PREDICT_STATS_EN
    exp_br = 32'd5;
    exp_mp = 32'd2;
`else
    exp_br = 32'd0;
    exp_mp = 32'd0;
`endif
    check_count++;
    if (branch_count !== exp_br)
      $display("[TB] FAIL stats_branch_count: got %0d expected %0d", branch_count, exp_br);
    else pass_count++;
    check_count++;
    if (mispredict_count !== exp_mp)
      $display("[TB] FAIL stats_mispredict_count: got %0d expected %0d", mispredict_count, exp_mp);
    else pass_count++;
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bltu_not_taken();
    test_back_to_back();
    test_flush_shadow();
    test_stats();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

Branch prediction and redirect controller for the pipelined RISC-V core. It holds a table of 2-bit saturating counters that supplies a taken/not-taken prediction to fetch. It resolves conditional branches in EX from the ALU flags and funct3, using the core's standard condition semantics. On a misprediction it sequences a one-cycle PC redirect and a two-cycle pipeline flush.

## Interface
Parameters:
- ENTRIES, 16: counter-table depth; power of two, minimum 2
- PC_W, 32: PC width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_pc  in  PC_W  PC of the instruction in fetch
- pred_taken  out  1  prediction for if_pc (combinational)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_funct3  in  3  branch funct3
- ex_pred_taken  in  1  prediction carried down with the EX instruction
- ex_pc  in  PC_W  PC of the EX instruction
- ex_target  in  PC_W  computed branch target
- Carry_Flag, Zero_Flag, Overflow_Flag, Sign_Flag  in  1 each  ALU flags for the EX compare
- redirect_valid  out  1  load redirect_pc into the PC
- redirect_pc  out  PC_W  corrected fetch address
- flush  out  1  squash IF/ID and ID/EX contents
- branch_count, mispredict_count  out  32 each  statistics (see Configuration)

## Operation
- Table index: if_pc / ex_pc bits [log2(ENTRIES)+1:2]. Prediction is counter bit 1.
- Resolution, evaluated when ex_valid & ex_branch & state==IDLE:
  - BEQ (000): taken = Z.
  - BNE (001): taken = !Z.
  - BLT (100): taken = V!=S.
  - BGE (101): taken = V==S.
  - BLTU (110): taken = !C.
  - BGEU (111): taken = C.
- funct3 010/011 is ignored: no counter update, no redirect, no statistics.
- Counter update on the resolving edge: taken saturates up to 3; not-taken saturates down to 0.
- Mispredict is taken != ex_pred_taken. redirect_pc = taken ? ex_target : ex_pc+4, registered. PC_W arithmetic wraps modulo 2^PC_W.
- FSM states and transitions:
  - IDLE to FLUSH1 on mispredict; otherwise stays IDLE.
  - FLUSH1 always goes to FLUSH2.
  - FLUSH2 always goes to IDLE.
- Outputs per state:
  - IDLE: redirect_valid=0, flush=0.
  - FLUSH1: redirect_valid=1, flush=1.
  - FLUSH2: redirect_valid=0, flush=1.
- In FLUSH1 and FLUSH2, EX holds wrong-path instructions. ex_valid/ex_branch are ignored: no update, no new mispredict.
- Same-cycle table read and write to the same index: pred_taken returns the pre-update value.
- Reset:
  - All counters go to 2'b01 (weakly not-taken).
  - State goes to IDLE.
  - redirect_valid=0, flush=0, redirect_pc=0, statistics=0.
  - pred_taken therefore reads 0 after reset.
  - Reset asserted in FLUSH1/FLUSH2 aborts the sequence; outputs are 0 on the next cycle.

## Timing
- pred_taken: zero-cycle combinational read from if_pc.
- Mispredict resolved in cycle N (sampled at edge N):
  - redirect_valid high in cycle N+1 only.
  - flush high in cycles N+1 and N+2.
  - A new branch can be resolved in cycle N+3.
- Correct predictions cause no bubbles. The counter change is visible to pred_taken from cycle N+1.
- All outputs except pred_taken are driven from flops.

## Configuration
- Macro BRANCH_PREDICT_STATS_EN.
- Defined: branch_count increments on every resolved branch (funct3 in {000,001,100,101,110,111}, IDLE). mispredict_count increments on every mispredict. Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports are present and tied to 0, and no counter flops are inferred.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Expect pred_taken=0 for every if_pc; redirect_valid=0, flush=0, redirect_pc=0.
- BEQ mispredict: ex_pc=0x100, ex_target=0x80, Z=1, ex_pred_taken=0. Expect redirect_valid=1 with redirect_pc=0x80 in N+1, flush=1 in N+1..N+2. if_pc=0x100 then predicts 1 (counter 2).
- BLTU not-taken mispredict: ex_pc=0x200, C=1, ex_pred_taken=1 after training. Expect redirect_pc=0x204.
- Saturation: four consecutive taken BGE (V=S=0) at ex_pc=0x40, correctly predicted after the first. Expect a single redirect only (the first), counter held at 3. One not-taken then still predicts 1.
- Flush shadow: mispredict, then ex_valid=1 ex_branch=1 with mispredicting flags in FLUSH1 and FLUSH2. Expect no extra redirect, counters unchanged. rst_n=0 in FLUSH1 then gives flush=0 next cycle.
- Stats (macro on): 5 branches with 2 mispredicts, plus one funct3=010. Expect branch_count=5, mispredict_count=2. Macro off: both read 0.
